// File: rtl/dm_cache_pkg.sv
// Shared types and derived-width helpers for the direct-mapped read cache.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned index_w,
                                               input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned calc_blk_w(input int unsigned word_w,
                                               input int unsigned offset_w);
        return word_w << offset_w;
    endfunction

endpackage

// File: rtl/dm_cache_line_ram.sv
// Tag and data storage for the cache lines: one refill write port, one async read port.
module dm_cache_line_ram #(
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned BLK_W   = 128
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLK_W-1:0]   i_wr_data,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLK_W-1:0]   o_rd_data
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [TAG_W-1:0] r_tag  [LINES];
    logic [BLK_W-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_tag  = r_tag[i_rd_index];
    assign o_rd_data = r_data[i_rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller with req/ack refill, flush and hit statistics.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cpu_req,
    input  logic [ADDR_W-1:0]                      cpu_addr,
    input  logic                                   flush,
    output logic                                   cpu_ready,
    output logic [WORD_W-1:0]                      cpu_rdata,
    output logic                                   busy,
    output logic                                   mem_req,
    output logic [ADDR_W-OFFSET_W-1:0]             mem_addr,
    input  logic                                   mem_ack,
    input  logic [calc_blk_w(WORD_W, OFFSET_W)-1:0] mem_rdata,
    output logic [CNT_W-1:0]                       access_count,
    output logic [CNT_W-1:0]                       hit_count
);

    localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int unsigned BLK_W  = calc_blk_w(WORD_W, OFFSET_W);
    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned WORDS  = 1 << OFFSET_W;
    localparam int unsigned BADR_W = ADDR_W - OFFSET_W;

    state_e                r_state;
    logic [LINES-1:0]      r_valid;
    logic                  r_cpu_ready;
    logic [WORD_W-1:0]     r_cpu_rdata;
    logic                  r_busy;
    logic                  r_mem_req;
    logic [BADR_W-1:0]     r_mem_addr;
    logic [OFFSET_W-1:0]   r_offset;
    logic [CNT_W-1:0]      r_access;
    logic [CNT_W-1:0]      r_hits;

    logic [OFFSET_W-1:0]   w_offset;
    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [BLK_W-1:0]      w_rd_data;
    logic                  w_hit;
    logic                  w_wr_en;
    logic [INDEX_W-1:0]    w_fill_index;
    logic [TAG_W-1:0]      w_fill_tag;
    logic [WORD_W-1:0]     w_rd_words  [WORDS];
    logic [WORD_W-1:0]     w_ack_words [WORDS];

    assign w_offset     = cpu_addr[OFFSET_W-1:0];
    assign w_index      = cpu_addr[OFFSET_W +: INDEX_W];
    assign w_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_hit        = r_valid[w_index] && (w_rd_tag == w_tag);
    assign w_wr_en      = (r_state == MISS) && mem_ack;
    assign w_fill_index = r_mem_addr[INDEX_W-1:0];
    assign w_fill_tag   = r_mem_addr[BADR_W-1 -: TAG_W];

    // Split both the stored line and the incoming refill block into words for offset selection.
    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign w_rd_words[g]  = w_rd_data[g*WORD_W +: WORD_W];
        assign w_ack_words[g] = mem_rdata[g*WORD_W +: WORD_W];
    end

    dm_cache_line_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .BLK_W   (BLK_W)
    ) u_line_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_fill_index),
        .i_wr_tag   (w_fill_tag),
        .i_wr_data  (mem_rdata),
        .i_rd_index (w_index),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_offset    <= '0;
            r_access    <= '0;
            r_hits      <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (cpu_req) begin
                        if (r_access != '1) r_access <= r_access + 1'b1;
                        if (w_hit) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= w_rd_words[w_offset];
                            if (r_hits != '1) r_hits <= r_hits + 1'b1;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {w_tag, w_index};
                            r_offset   <= w_offset;
                            r_busy     <= 1'b1;
                            r_state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    // Return the requested word straight from the refill block.
                    if (mem_ack) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_mem_req             <= 1'b0;
                        r_cpu_ready           <= 1'b1;
                        r_cpu_rdata           <= w_ack_words[r_offset];
                        r_state               <= RESP;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_ready    = r_cpu_ready;
    assign cpu_rdata    = r_cpu_rdata;
    assign busy         = r_busy;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign access_count = r_access;
    assign hit_count    = r_hits;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed vector bench for dm_cache_ctrl (default geometry, 4-bit counters).
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic [14:0]  cpu_addr;
    logic         flush;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         busy;
    logic         mem_req;
    logic [12:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_rdata;
    logic [3:0]   access_count;
    logic [3:0]   hit_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_word = 32'h0;

    typedef struct {
        logic        flush;
        logic [14:0] addr;
        logic        exp_miss;
        logic        exp_ready;
        logic [12:0] exp_maddr;
        int          ack_dly;
        logic [31:0] exp_word;
        int          exp_acc;
        int          exp_hit;
    } vec_t;

    vec_t vecs[13];

    dm_cache_ctrl #(.CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .flush        (flush),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .access_count (access_count),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    // Main memory model: word o of block b is {16'hAAAA ^ (b-1), o}.
    function automatic logic [127:0] make_blk(input logic [12:0] ba);
        logic [127:0] b;
        for (int o = 0; o < 4; o++)
            b[o*32 +: 32] = {16'hAAAA ^ (16'(ba) - 16'd1), 16'(o)};
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        cpu_addr = v.addr;
        cpu_req  = 1'b1;
        flush    = v.flush;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        flush   = 1'b0;
        if (v.exp_miss) begin
            check("miss_req",     32'(mem_req),   32'd1);
            check("miss_addr",    32'(mem_addr),  32'(v.exp_maddr));
            check("miss_busy",    32'(busy),      32'd1);
            check("miss_noready", 32'(cpu_ready), 32'd0);
            for (int d = 0; d < v.ack_dly; d++) begin
                @(negedge clk);
                check("hold_req",  32'(mem_req),  32'd1);
                check("hold_addr", 32'(mem_addr), 32'(v.exp_maddr));
            end
            mem_ack   = 1'b1;
            mem_rdata = make_blk(v.exp_maddr);
            @(negedge clk);
            mem_ack = 1'b0;
            check("resp_ready", 32'(cpu_ready), 32'd1);
            check("resp_data",  cpu_rdata,      v.exp_word);
            check("resp_noreq", 32'(mem_req),   32'd0);
            check("resp_busy",  32'(busy),      32'd1);
            last_word = v.exp_word;
            @(negedge clk);
            check("idle_ready", 32'(cpu_ready), 32'd0);
            check("idle_busy",  32'(busy),      32'd0);
            check("idle_hold",  cpu_rdata,      last_word);
        end else if (v.exp_ready) begin
            check("hit_ready", 32'(cpu_ready), 32'd1);
            check("hit_data",  cpu_rdata,      v.exp_word);
            check("hit_noreq", 32'(mem_req),   32'd0);
            last_word = v.exp_word;
        end else begin
            check("drop_ready", 32'(cpu_ready), 32'd0);
            check("drop_noreq", 32'(mem_req),   32'd0);
            check("drop_hold",  cpu_rdata,      last_word);
        end
        check("acc_cnt", 32'(access_count), 32'(v.exp_acc));
        check("hit_cnt", 32'(hit_count),    32'(v.exp_hit));
    endtask

    initial begin
        vec_t v;
        //            flush addr     miss  rdy   maddr    dly word           acc hit
        vecs[0]  = '{1'b0, 15'h0005, 1'b1, 1'b1, 13'h001, 0, 32'hAAAA0001,  1, 0};
        vecs[1]  = '{1'b0, 15'h0004, 1'b0, 1'b1, 13'h000, 0, 32'hAAAA0000,  2, 1};
        vecs[2]  = '{1'b0, 15'h0005, 1'b0, 1'b1, 13'h000, 0, 32'hAAAA0001,  3, 2};
        vecs[3]  = '{1'b0, 15'h0006, 1'b0, 1'b1, 13'h000, 0, 32'hAAAA0002,  4, 3};
        vecs[4]  = '{1'b0, 15'h0007, 1'b0, 1'b1, 13'h000, 0, 32'hAAAA0003,  5, 4};
        vecs[5]  = '{1'b0, 15'h1004, 1'b1, 1'b1, 13'h401, 2, 32'hAEAA0000,  6, 4};
        vecs[6]  = '{1'b0, 15'h1006, 1'b0, 1'b1, 13'h000, 0, 32'hAEAA0002,  7, 5};
        vecs[7]  = '{1'b0, 15'h0004, 1'b1, 1'b1, 13'h001, 1, 32'hAAAA0000,  8, 5};
        vecs[8]  = '{1'b0, 15'h0008, 1'b1, 1'b1, 13'h002, 0, 32'hAAAB0000,  9, 5};
        vecs[9]  = '{1'b0, 15'h000B, 1'b0, 1'b1, 13'h000, 0, 32'hAAAB0003, 10, 6};
        vecs[10] = '{1'b1, 15'h0008, 1'b0, 1'b0, 13'h000, 0, 32'h00000000, 10, 6};
        vecs[11] = '{1'b0, 15'h0008, 1'b1, 1'b1, 13'h002, 3, 32'hAAAB0000, 11, 6};
        vecs[12] = '{1'b0, 15'h0005, 1'b1, 1'b1, 13'h001, 0, 32'hAAAA0001, 12, 6};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cpu_ready),    32'd0);
        check("rst_rdata", cpu_rdata,         32'd0);
        check("rst_req",   32'(mem_req),      32'd0);
        check("rst_addr",  32'(mem_addr),     32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_acc",   32'(access_count), 32'd0);
        check("rst_hit",   32'(hit_count),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Back-to-back hits past the 4-bit counter limit.
        for (int i = 0; i < 20; i++) begin
            v = '{1'b0, 15'h0004 + 15'(i % 4), 1'b0, 1'b1, 13'h000, 0,
                  32'hAAAA0000 | 32'(i % 4),
                  (13 + i > 15) ? 15 : 13 + i, (7 + i > 15) ? 15 : 7 + i};
            run_vec(v);
        end

        // Reset in the middle of a refill.
        cpu_addr = 15'h0010;
        cpu_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        check("abort_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_req",  32'(mem_req),      32'd0);
        check("abort_busy", 32'(busy),         32'd0);
        check("abort_acc",  32'(access_count), 32'd0);
        check("abort_hit",  32'(hit_count),    32'd0);
        last_word = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{1'b0, 15'h0005, 1'b1, 1'b1, 13'h001, 0, 32'hAAAA0001, 1, 0});

        // Request while busy is dropped; refill of block 4 still completes.
        cpu_addr = 15'h0010;
        cpu_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_addr = 15'h0005;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        check("busy_drop_ready", 32'(cpu_ready),    32'd0);
        check("busy_drop_req",   32'(mem_req),      32'd1);
        check("busy_drop_acc",   32'(access_count), 32'd2);
        check("busy_drop_hit",   32'(hit_count),    32'd0);
        mem_ack   = 1'b1;
        mem_rdata = make_blk(13'h004);
        @(negedge clk);
        mem_ack = 1'b0;
        check("busy_resp_ready", 32'(cpu_ready), 32'd1);
        check("busy_resp_data",  cpu_rdata,      32'hAAA90000);
        last_word = 32'hAAA90000;
        @(negedge clk);

        // Stray ack while idle must not start anything or corrupt a line.
        mem_ack   = 1'b1;
        mem_rdata = '1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_req",   32'(mem_req),   32'd0);
        check("stray_ack_ready", 32'(cpu_ready), 32'd0);
        run_vec('{1'b0, 15'h0005, 1'b0, 1'b1, 13'h000, 0, 32'hAAAA0001, 3, 1});
        run_vec('{1'b0, 15'h0013, 1'b0, 1'b1, 13'h000, 0, 32'hAAA90003, 4, 2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
